hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard and stall controller for the 5-stage RV32I core. It is the producer-side counterpart of the EXE/MEM forwarding bypass: it detects the hazards that bypassing cannot resolve and drives the per-stage write-enable, flush and bubble controls. Those hazards are load-use, taken branch/jump redirects, outstanding instruction-fetch responses after a redirect, and multi-cycle data-memory accesses. It sits beside the forwarding unit in the ID/EXE boundary logic and also keeps saturating stall and flush counters for performance debug.

## Interface
- CNT_W, 16, width of stall_cnt and flush_cnt
- clk  in  1  core clock
- rst_n  in  1  asynchronous, active-low reset
- ID_rs1_addr, ID_rs2_addr  in  5  source registers of the instruction in ID
- ID_rs1_used, ID_rs2_used  in  1  ID instruction actually reads rs1/rs2
- EXE_MemRead  in  1  EXE instruction is a load
- EXE_rd_addr  in  5  EXE destination register
- EXE_branch_taken  in  1  redirect resolved in EXE this cycle
- IM_busy  in  1  instruction fetch issued, response not yet returned
- IM_valid  in  1  instruction-memory response valid this cycle
- MEM_req  in  1  MEM stage holds a load/store
- DM_ready  in  1  data-memory access completes this cycle
- PC_write, IF_ID_write, ID_EXE_write, EXE_MEM_write  out  1  stage register enables
- IF_ID_flush, ID_EXE_flush  out  1  replace stage contents with a NOP
- MEM_WB_bubble  out  1  write a NOP into MEM/WB
- IM_discard  out  1  drop the current IM response
- stall_cnt  out  CNT_W  cycles with PC_write=0 (saturating)
- flush_cnt  out  CNT_W  redirect events (saturating)

## Operation
- Terms used below:
  - dm_wait = MEM_req & !DM_ready.
  - lu = EXE_MemRead & EXE_rd_addr!=0 & ((ID_rs1_used & rs1==rd) | (ID_rs2_used & rs2==rd)).
- FSM states are RUN, DM_WAIT and DRAIN. Outputs are Mealy, computed from the state and the current inputs.
- Defaults: all write enables are 1; flush, bubble and discard are 0.
- RUN uses fixed priority:
  1. dm_wait: freeze. PC, IF_ID, ID_EXE and EXE_MEM writes are 0 and MEM_WB_bubble=1. Next state DM_WAIT.
  2. EXE_branch_taken: IF_ID_flush=1, ID_EXE_flush=1, PC_write=1 (loads target), flush_cnt++. If IM_busy & !IM_valid, next state DRAIN, otherwise RUN. A response arriving in the same cycle is squashed by IF_ID_flush.
  3. lu: PC_write=0, IF_ID_write=0, ID_EXE_flush=1. Stays in RUN. A load-use in ID is ignored when a branch is taken, because the ID instruction is squashed.
- DM_WAIT:
  - While dm_wait holds, freeze as in RUN rule 1.
  - In the cycle DM_ready=1, the freeze is released and RUN rules 2–3 are evaluated in that same cycle. The next state follows those rules.
- DRAIN:
  - PC_write=0, IF_ID_write=0, IF_ID_flush=1, IM_discard=IM_valid.
  - When IM_valid=1, the response is discarded. Next state is DM_WAIT if dm_wait, otherwise RUN.
  - dm_wait during DRAIN also freezes EXE_MEM and asserts MEM_WB_bubble, but does not change the exit condition.
  - EXE_branch_taken cannot occur in DRAIN because ID_EXE carries a bubble.
- Counters: stall_cnt increments in every cycle with PC_write=0. Both counters saturate at all-ones.

## Timing
- Reset (rst_n=0, asynchronous): state=RUN and counters=0. All write enables, flushes, bubble and discard are 0 while rst_n is low.
- Control outputs have zero latency (combinational on the inputs). Counters update at the following clk edge.
- Load-use costs exactly 1 stall cycle. The following cycle lu is naturally false because the load has moved to MEM.
- A taken branch costs 2 squashed instructions, plus N DRAIN cycles until the stale IM response arrives.
- The DM freeze lasts for every cycle MEM_req=1 & DM_ready=0. A DM_ready=1 in the first MEM cycle gives zero stall.
- rst_n asserted mid-DRAIN or mid-DM_WAIT returns the FSM to RUN. No pending discard survives reset.

## Structure
- The shared package holds:
  - state encoding: RUN=2'd0, DM_WAIT=2'd1, DRAIN=2'd2
  - REG_X0=5'd0
  - CNT_W default
- One natural sub-module, sat_counter (CNT_W, inc), instantiated twice.
- All other logic is a single FSM always_ff block plus one combinational output block.

## Test plan
- Load x5 in EXE (EXE_MemRead=1, rd=5), ID rs1=5 used → exactly 1 cycle with PC_write=0, IF_ID_write=0, ID_EXE_flush=1, then normal flow; stall_cnt=1.
- Load to rd=0 with ID rs1=0 used → no stall; same case with ID_rs1_used=0 → no stall.
- EXE_branch_taken=1 together with lu=1 → IF_ID_flush=ID_EXE_flush=1, PC_write=1; flush_cnt=1, stall_cnt=0.
- Branch taken with IM_busy=1, IM_valid=0, response after 3 cycles → DRAIN for 3 cycles, IM_discard=1 only on the response cycle, RUN next; stall_cnt=3.
- MEM_req=1, DM_ready low 4 cycles then high → 4 freeze cycles with MEM_WB_bubble=1, release on cycle 5; a pending lu in that release cycle stalls 1 more.
- rst_n pulsed low mid-DRAIN → all outputs 0 immediately, counters 0, RUN after release, no discard issued; force a counter to all-ones → holds all-ones.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared types and constants for the pipeline hazard controller
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_DM_WAIT = 2'd1,
        ST_DRAIN   = 2'd2
    } state_t;

    localparam logic [4:0] REG_X0    = 5'd0;
    localparam int         CNT_W_DEF = 16;

    // x0 is hardwired to zero, so a load targeting it never creates a dependency
    function automatic logic load_use(
        input logic       mem_read,
        input logic [4:0] rd,
        input logic [4:0] rs1,
        input logic       rs1_used,
        input logic [4:0] rs2,
        input logic       rs2_used
    );
        return mem_read && (rd != REG_X0) &&
               ((rs1_used && (rs1 == rd)) || (rs2_used && (rs2 == rd)));
    endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// rtl/hazard_ctrl_sat_counter.sv - saturating event counter for performance debug
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - load-use / redirect / IM drain / DM wait stall and flush controller
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [4:0]       i_id_rs1_addr,
    input  logic [4:0]       i_id_rs2_addr,
    input  logic             i_id_rs1_used,
    input  logic             i_id_rs2_used,
    input  logic             i_exe_mem_read,
    input  logic [4:0]       i_exe_rd_addr,
    input  logic             i_exe_branch_taken,
    input  logic             i_im_busy,
    input  logic             i_im_valid,
    input  logic             i_mem_req,
    input  logic             i_dm_ready,
    output logic             o_pc_write,
    output logic             o_if_id_write,
    output logic             o_id_exe_write,
    output logic             o_exe_mem_write,
    output logic             o_if_id_flush,
    output logic             o_id_exe_flush,
    output logic             o_mem_wb_bubble,
    output logic             o_im_discard,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt
);

    state_t r_state;
    logic   w_dm_wait;
    logic   w_lu;
    logic   w_flush_inc;
    logic   w_stall_inc;

    assign w_dm_wait = i_mem_req && !i_dm_ready;
    assign w_lu      = load_use(i_exe_mem_read, i_exe_rd_addr,
                                i_id_rs1_addr, i_id_rs1_used,
                                i_id_rs2_addr, i_id_rs2_used);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_RUN;
        end else begin
            case (r_state)
                ST_DRAIN: begin
                    if (i_im_valid) begin
                        r_state <= w_dm_wait ? ST_DM_WAIT : ST_RUN;
                    end
                end
                // DM_WAIT with DM_ready behaves exactly like RUN in that cycle
                default: begin
                    if (w_dm_wait) begin
                        r_state <= ST_DM_WAIT;
                    end else if (i_exe_branch_taken && i_im_busy && !i_im_valid) begin
                        r_state <= ST_DRAIN;
                    end else begin
                        r_state <= ST_RUN;
                    end
                end
            endcase
        end
    end

    always_comb begin
        o_pc_write      = 1'b1;
        o_if_id_write   = 1'b1;
        o_id_exe_write  = 1'b1;
        o_exe_mem_write = 1'b1;
        o_if_id_flush   = 1'b0;
        o_id_exe_flush  = 1'b0;
        o_mem_wb_bubble = 1'b0;
        o_im_discard    = 1'b0;
        w_flush_inc     = 1'b0;

        case (r_state)
            ST_DRAIN: begin
                o_pc_write    = 1'b0;
                o_if_id_write = 1'b0;
                o_if_id_flush = 1'b1;
                o_im_discard  = i_im_valid;
                if (w_dm_wait) begin
                    o_exe_mem_write = 1'b0;
                    o_mem_wb_bubble = 1'b1;
                end
            end
            default: begin
                if (w_dm_wait) begin
                    o_pc_write      = 1'b0;
                    o_if_id_write   = 1'b0;
                    o_id_exe_write  = 1'b0;
                    o_exe_mem_write = 1'b0;
                    o_mem_wb_bubble = 1'b1;
                end else if (i_exe_branch_taken) begin
                    // squashes the ID instruction, so any load-use on it is moot
                    o_if_id_flush  = 1'b1;
                    o_id_exe_flush = 1'b1;
                    w_flush_inc    = 1'b1;
                end else if (w_lu) begin
                    o_pc_write     = 1'b0;
                    o_if_id_write  = 1'b0;
                    o_id_exe_flush = 1'b1;
                end
            end
        endcase

        if (!i_rst_n) begin
            o_pc_write      = 1'b0;
            o_if_id_write   = 1'b0;
            o_id_exe_write  = 1'b0;
            o_exe_mem_write = 1'b0;
            o_if_id_flush   = 1'b0;
            o_id_exe_flush  = 1'b0;
            o_mem_wb_bubble = 1'b0;
            o_im_discard    = 1'b0;
            w_flush_inc     = 1'b0;
        end
    end

    assign w_stall_inc = !o_pc_write;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_inc   (w_stall_inc),
        .o_cnt   (o_stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_inc   (w_flush_inc),
        .o_cnt   (o_flush_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed scoreboard bench for hazard_ctrl
module tb_hazard_ctrl;

    localparam int CW = 4;

    // expected control vector: {pc_w, if_id_w, id_exe_w, exe_mem_w, if_id_f, id_exe_f, bubble, discard}
    localparam logic [7:0] C_RST   = 8'b0000_0000;
    localparam logic [7:0] C_NORM  = 8'b1111_0000;
    localparam logic [7:0] C_FRZ   = 8'b0000_0010;
    localparam logic [7:0] C_BR    = 8'b1111_1100;
    localparam logic [7:0] C_LU    = 8'b0011_0100;
    localparam logic [7:0] C_DRN   = 8'b0011_1000;
    localparam logic [7:0] C_DRN_D = 8'b0011_1001;
    localparam logic [7:0] C_DRN_W = 8'b0010_1010;
    localparam logic [7:0] C_DRN_WD= 8'b0010_1011;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [4:0]    rs1, rs2, rd;
    logic          u1, u2, mr, br, busy, val, mreq, dmr;
    logic          pc_w, ifid_w, idexe_w, exemem_w, ifid_f, idexe_f, bub, disc;
    logic [CW-1:0] stall_cnt, flush_cnt;

    typedef struct packed {
        logic [7:0]    ctrl;
        logic [CW-1:0] s;
        logic [CW-1:0] f;
    } exp_t;

    exp_t          sb_q[$];
    int            n_cmp  = 0;
    int            n_fail = 0;
    logic [CW-1:0] m_s = '0;
    logic [CW-1:0] m_f = '0;

    always #5 clk = ~clk;

    hazard_ctrl #(.CNT_W(CW)) dut (
        .i_clk              (clk),
        .i_rst_n            (rst_n),
        .i_id_rs1_addr      (rs1),
        .i_id_rs2_addr      (rs2),
        .i_id_rs1_used      (u1),
        .i_id_rs2_used      (u2),
        .i_exe_mem_read     (mr),
        .i_exe_rd_addr      (rd),
        .i_exe_branch_taken (br),
        .i_im_busy          (busy),
        .i_im_valid         (val),
        .i_mem_req          (mreq),
        .i_dm_ready         (dmr),
        .o_pc_write         (pc_w),
        .o_if_id_write      (ifid_w),
        .o_id_exe_write     (idexe_w),
        .o_exe_mem_write    (exemem_w),
        .o_if_id_flush      (ifid_f),
        .o_id_exe_flush     (idexe_f),
        .o_mem_wb_bubble    (bub),
        .o_im_discard       (disc),
        .o_stall_cnt        (stall_cnt),
        .o_flush_cnt        (flush_cnt)
    );

    task automatic drv(input logic [4:0] a1, input logic [4:0] a2, input logic x1, input logic x2,
                       input logic lmr, input logic [4:0] lrd, input logic lbr, input logic lbusy,
                       input logic lval, input logic lmreq, input logic ldmr);
        rs1 = a1; rs2 = a2; u1 = x1; u2 = x2; mr = lmr; rd = lrd;
        br = lbr; busy = lbusy; val = lval; mreq = lmreq; dmr = ldmr;
    endtask

    task automatic idle();
        drv(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // drive is done by the caller at a negedge; expectations enter the scoreboard here
    task automatic step(input string tag, input logic [7:0] ec);
        exp_t e;
        exp_t got;
        if (!rst_n) begin
            m_s = '0;
            m_f = '0;
        end
        e.ctrl = ec;
        e.s    = m_s;
        e.f    = m_f;
        sb_q.push_back(e);
        #2;
        got.ctrl = {pc_w, ifid_w, idexe_w, exemem_w, ifid_f, idexe_f, bub, disc};
        got.s    = stall_cnt;
        got.f    = flush_cnt;
        e = sb_q.pop_front();
        n_cmp++;
        assert (got.ctrl === e.ctrl) else begin
            n_fail++;
            $error("FAIL %s ctrl: observed %b expected %b", tag, got.ctrl, e.ctrl);
        end
        n_cmp++;
        assert (got.s === e.s) else begin
            n_fail++;
            $error("FAIL %s stall_cnt: observed %0d expected %0d", tag, got.s, e.s);
        end
        n_cmp++;
        assert (got.f === e.f) else begin
            n_fail++;
            $error("FAIL %s flush_cnt: observed %0d expected %0d", tag, got.f, e.f);
        end
        if (rst_n) begin
            if (!ec[7] && (m_s != {CW{1'b1}})) m_s = m_s + 1'b1;
            if (ec[3] && ec[2] && (m_f != {CW{1'b1}})) m_f = m_f + 1'b1;
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        step("reset", C_RST);
        rst_n = 1'b1;
        step("idle", C_NORM);

        // load-use on rs1, then natural flow
        drv(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("lu_rs1", C_LU);
        idle();
        step("lu_after", C_NORM);

        // x0 destination and unused source never stall; rs2 match does
        drv(5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("lu_x0", C_NORM);
        drv(5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("lu_unused", C_NORM);
        drv(5'd1, 5'd7, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("lu_rs2", C_LU);

        // taken branch overrides a simultaneous load-use
        drv(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step("br_lu", C_BR);
        idle();
        step("br_after", C_NORM);

        // branch with an outstanding fetch: three drain cycles, discard on the response
        drv(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step("br_busy", C_BR);
        drv(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("drain1", C_DRN);
        step("drain2", C_DRN);
        drv(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step("drain3_resp", C_DRN_D);
        idle();
        step("drain_exit", C_NORM);

        // four DM wait cycles, release with a pending load-use
        for (int i = 0; i < 4; i++) begin
            drv(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            step("dm_freeze", C_FRZ);
        end
        drv(5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        step("dm_release_lu", C_LU);
        idle();
        step("dm_after", C_NORM);
        drv(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        step("dm_zero_stall", C_NORM);

        // DM wait overlapping a drain: exit to DM_WAIT on the response
        drv(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step("br_busy2", C_BR);
        drv(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        step("drain_dm", C_DRN_W);
        drv(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        step("drain_dm_resp", C_DRN_WD);
        drv(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step("dm_wait_after_drain", C_FRZ);
        drv(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        step("dm_release", C_NORM);

        // drive stall_cnt into saturation and hold it there
        drv(5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step("lu_sat", C_LU);
        end
        idle();
        step("sat_hold", C_NORM);

        // reset in the middle of a drain with a response arriving
        drv(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step("br_busy3", C_BR);
        drv(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("drain_pre_rst", C_DRN);
        drv(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b0;
        step("rst_mid_drain", C_RST);
        rst_n = 1'b1;
        drv(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step("post_rst_run", C_NORM);
        idle();
        step("post_rst_idle", C_NORM);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
